payload_byte_feeder: RTL

PAYLOAD_BYTE_FEEDER -- requirements
Module: payload_byte_feeder

---
 rtl/payload_byte_feeder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/payload_byte_feeder.sv
// Serializes 64-bit keep-qualified payload words into a byte stream with
// sod/eod framing, a one-hot byte decode and a saturating byte count.
//
// state | meaning
// IDLE  | waiting for the first word of a packet, s_tready high
// SOD   | one-cycle start pulse, byte counter cleared
// SHIFT | emitting kept lanes one per cycle, or waiting for the next word
// EOD   | one-cycle end pulse, pkt_len presents the byte count
module payload_byte_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      s_tdata,
    input  logic [7:0]       s_tkeep,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic             sod,
    output logic             en,
    output logic             eod,
    output logic [7:0]       byte_out,
    output logic [255:0]     dec,
    output logic [LEN_W-1:0] pkt_len
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOD   = 2'd1,
        SHIFT = 2'd2,
        EOD   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [63:0]      hold_data;
    logic [63:0]      hold_data_nx;
    logic [7:0]       hold_rem;
    logic [7:0]       hold_rem_nx;
    logic             hold_last;
    logic             hold_last_nx;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_nx;

    logic             accept;
    logic             load;
    logic             emit;
    logic [63:0]      src_data;
    logic [7:0]       src_keep;
    logic [2:0]       lane;
    logic [7:0]       lane_byte;

    logic             tready_nx;
    logic             sod_nx;
    logic             en_nx;
    logic             eod_nx;
    logic [7:0]       byte_nx;
    logic [255:0]     dec_nx;
    logic [LEN_W-1:0] len_nx;

    assign accept = s_tvalid && s_tready;

    // A word accepted mid-packet bypasses the holding register for its first
    // lane so that it is emitted on the very next cycle.
    assign load     = (state == SHIFT) && (hold_rem == 8'd0) && !hold_last && accept;
    assign src_data = load ? s_tdata : hold_data;
    assign src_keep = load ? s_tkeep : hold_rem;

    always_comb begin
        lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (src_keep[i]) begin
                lane = 3'(i);
            end
        end
    end

    assign lane_byte = src_data[{lane, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_rem  <= '0;
            hold_last <= 1'b0;
            count     <= '0;
            s_tready  <= 1'b0;
            sod       <= 1'b0;
            en        <= 1'b0;
            eod       <= 1'b0;
            byte_out  <= '0;
            dec       <= '0;
            pkt_len   <= '0;
        end else begin
            state     <= state_nx;
            hold_data <= hold_data_nx;
            hold_rem  <= hold_rem_nx;
            hold_last <= hold_last_nx;
            count     <= count_nx;
            s_tready  <= tready_nx;
            sod       <= sod_nx;
            en        <= en_nx;
            eod       <= eod_nx;
            byte_out  <= byte_nx;
            dec       <= dec_nx;
            pkt_len   <= len_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hold_data_nx = hold_data;
        hold_rem_nx  = hold_rem;
        hold_last_nx = hold_last;
        count_nx     = count;
        emit         = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx     = SOD;
                    hold_data_nx = s_tdata;
                    hold_rem_nx  = s_tkeep;
                    hold_last_nx = s_tlast;
                    count_nx     = '0;
                end
            end
            SOD: begin
                state_nx = SHIFT;
                emit     = (hold_rem != 8'd0);
            end
            SHIFT: begin
                if (hold_rem != 8'd0) begin
                    emit = 1'b1;
                end else if (hold_last) begin
                    state_nx = EOD;
                end else if (load) begin
                    hold_data_nx = s_tdata;
                    hold_rem_nx  = s_tkeep;
                    hold_last_nx = s_tlast;
                    emit         = (s_tkeep != 8'd0);
                end
            end
            EOD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (emit) begin
            hold_rem_nx = src_keep & (src_keep - 8'd1);
            if (count != '1) begin
                count_nx = count + LEN_W'(1);
            end
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        tready_nx = 1'b0;
        sod_nx    = (state_nx == SOD);
        eod_nx    = (state_nx == EOD);
        en_nx     = emit;
        byte_nx   = byte_out;
        dec_nx    = '0;
        len_nx    = pkt_len;
        if (state_nx == IDLE) begin
            tready_nx = 1'b1;
        end else if ((state_nx == SHIFT) && (hold_rem_nx == 8'd0) && !hold_last_nx) begin
            tready_nx = 1'b1;
        end
        if (emit) begin
            byte_nx           = lane_byte;
            dec_nx[lane_byte] = 1'b1;
        end
        if (state_nx == EOD) begin
            len_nx = count_nx;
        end
    end

endmodule
